mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Load/store initiator for the byte-addressed, big-endian, word-ported data memory. Accepts one byte, halfword or word load/store request per transaction from the CPU side over a valid/ready handshake, drives the memory's `rd`/`wr`/`addr`/`wdata` and samples its combinational `rdata`. Sub-word stores use read-modify-write; loads return sign- or zero-extended data. Sits between the datapath MEM stage and the data memory.

## Interface
- `ENTRIES`, 32, memory size in bytes; must match the attached data memory.
- `AW`, derived as ceil(log2(ENTRIES)) (5 at default), memory address width; not overridable.
- `clk`  in  1  clock; all state updates on posedge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept; equals (state==IDLE) && rst_n.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- `req_unsigned`  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data; sub-word data is taken from the low bits.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  consumer accepts response.
- `resp_rdata`  out  32  extended load data; 0 for stores and errors.
- `resp_err`  out  1  misaligned, out-of-range or unsupported request.
- `mem_rd`, `mem_wr`  out  1 each  memory strobes.
- `mem_addr`  out  AW  word-aligned byte address (low 2 bits always 0).
- `mem_wdata`  out  32  store word, big-endian.
- `mem_rdata`  in  32  combinational read data.

## Operation
- FSM states: IDLE, RD, WR, RESP. Accept on posedge with req_valid && req_ready; latch all req_* fields.
- Error check at accept, in priority order: size==11; halfword with addr[0]!=0; word with addr[1:0]!=0; addr > ENTRIES-4 (memory reads addr..addr+3); sub-word store when RMW is compiled out. On error go IDLE->RESP with resp_err=1; no memory strobe is ever asserted.
- Load: IDLE->RD->RESP. In RD, mem_rd=1 and mem_addr={addr[AW-1:2],2'b00}. At the end-of-RD posedge, capture mem_rdata and extract the lane: byte offset k maps to bits [31-8k -: 8]; halfword offset 0 maps to [31:16] and offset 2 to [15:0]. Extend per req_unsigned.
- Word store: IDLE->WR->RESP. In WR, mem_wr=1 and mem_wdata=req_wdata.
- Sub-word store: IDLE->RD->WR->RESP. Capture the word in RD. In WR, drive the captured word with the target lane replaced by req_wdata[7:0] or [15:0].
- RESP: resp_valid=1. resp_rdata and resp_err stay stable until resp_ready is sampled high, then go to IDLE.
- mem_* outputs decode from the state register plus latched fields only; there is no combinational path from req_* or resp_ready. Outside RD, mem_rd=0. Outside WR, mem_wr=0 and mem_wdata=0. In IDLE and RESP, mem_addr=0.

## Timing
- The memory commits writes on negedge within the WR cycle; the unit keeps mem_wr/mem_addr/mem_wdata stable for the whole WR cycle.
- Latency from accept posedge to first cycle with resp_valid=1:
  - error: 1 cycle
  - load or word store: 2 cycles
  - RMW store: 3 cycles
- Throughput: next accept at the earliest in the cycle after the resp handshake. req_ready=0 from accept until IDLE is re-entered.
- Reset values: state IDLE, all outputs 0 except req_ready (1 once rst_n is high), all latches 0.
- Reset mid-operation: asserting rst_n drops mem_wr immediately. A write is either fully committed or not performed. No response is produced for the aborted request.

## Configuration
- `MEM_ACCESS_RMW_EN` defined: byte and halfword stores are performed by read-modify-write.
- Undefined: RD-before-WR path and merge logic are not compiled. Sub-word stores complete with resp_err=1 in 1 cycle and no memory access. Loads and word stores are unaffected.

## Test plan
- SW addr 8 data 0x11223344, then LW addr 8 -> resp_rdata 0x11223344, err 0; each resp_valid exactly 2 cycles after its accept.
- SW addr 4 data 0x80FF0000; LB addr 4 -> 0xFFFFFF80; LBU addr 5 -> 0x000000FF; LH addr 4 -> 0xFFFF80FF; LHU addr 6 -> 0x00000000.
- With RMW: SW 8 0x11223344, SB addr 10 data 0xAB (resp at 3 cycles), LW 8 -> 0x1122AB44. Without RMW: SB -> err 1 after 1 cycle, LW 8 -> 0x11223344.
- LW addr 6 -> err 1; LH addr 29 -> err 1; LW addr 28 -> ok; LW addr 29 -> err 1; size 11 -> err 1; mem_rd/mem_wr never high for any erroring request.
- resp_ready held low 5 cycles after a load -> resp_valid, resp_rdata stable; req_ready 0; new req_valid ignored until handshake.
- SW 12 0xCAFEF00D; issue SB 12 0x00 and assert rst_n low during RD -> all outputs 0, mem_wr never high; LW 12 after reset -> 0xCAFEF00D.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Bundles the CPU-side request/response handshake and the data-memory port of mem_access_unit.
// slave is the unit's view; master is the view of the CPU plus the attached memory.
`default_nettype none

interface mem_access_unit_if #(
    parameter int ENTRIES = 32
);
    localparam int AW = $clog2(ENTRIES);

    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;

    logic          resp_valid;
    logic          resp_ready;
    logic [31:0]   resp_rdata;
    logic          resp_err;

    logic          mem_rd;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_err,
        input  resp_ready,
        output mem_rd, mem_wr, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_err,
        output resp_ready,
        input  mem_rd, mem_wr, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

`default_nettype wire

// File: rtl/mem_access_unit.sv
// Byte/halfword/word load-store initiator for a big-endian, word-ported data memory.
// Define MEM_ACCESS_RMW_EN to build sub-word stores as read-modify-write; otherwise they are rejected.
`default_nettype none

module mem_access_unit #(
    parameter int ENTRIES = 32
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    mem_access_unit_if.slave    bus
);
    localparam int          AW       = $clog2(ENTRIES);
    localparam logic [31:0] ADDR_MAX = 32'(ENTRIES - 4);
`ifdef MEM_ACCESS_RMW_EN
    localparam logic        RMW_EN   = 1'b1;
`else
    localparam logic        RMW_EN   = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_WR   = 2'b10,
        ST_RESP = 2'b11
    } state_t;

    state_t        state_r;
    logic [1:0]    size_r;
    logic [1:0]    off_r;
    logic          unsigned_r;
`ifdef MEM_ACCESS_RMW_EN
    logic          we_r;
    logic [15:0]   wdata_r;
`endif
    logic          mem_rd_r;
    logic          mem_wr_r;
    logic [AW-1:0] mem_addr_r;
    logic [31:0]   mem_wdata_r;
    logic          resp_valid_r;
    logic          resp_err_r;
    logic [31:0]   resp_rdata_r;
    logic          accept_err_s;

    // Rejection test applied to the live request at accept time, highest priority first.
    function automatic logic req_error(input logic [1:0] size, input logic [31:0] addr,
                                       input logic we);
        logic err;
        if (size == 2'b11) begin
            err = 1'b1;
        end else if ((size == 2'b01) && (addr[0] != 1'b0)) begin
            err = 1'b1;
        end else if ((size == 2'b10) && (addr[1:0] != 2'b00)) begin
            err = 1'b1;
        end else if (addr > ADDR_MAX) begin
            err = 1'b1;
        end else if (we && (size != 2'b10) && !RMW_EN) begin
            err = 1'b1;
        end else begin
            err = 1'b0;
        end
        return err;
    endfunction

    // Picks the addressed big-endian lane out of the memory word and extends it to 32 bits.
    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] off, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        h = off[1] ? word[15:0] : word[31:16];
        case (size)
            2'b00:   r = uns ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   r = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

`ifdef MEM_ACCESS_RMW_EN
    // Replaces the target byte or halfword lane of the old word with the new store data.
    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [15:0] data,
                                                input logic [1:0] size, input logic [1:0] off);
        logic [31:0] r;
        case (size)
            2'b00: begin
                case (off)
                    2'd0:    r = {data[7:0], word[23:0]};
                    2'd1:    r = {word[31:24], data[7:0], word[15:0]};
                    2'd2:    r = {word[31:16], data[7:0], word[7:0]};
                    default: r = {word[31:8], data[7:0]};
                endcase
            end
            2'b01:   r = off[1] ? {word[31:16], data} : {data, word[15:0]};
            default: r = word;
        endcase
        return r;
    endfunction
`endif

    assign accept_err_s = req_error(bus.req_size, bus.req_addr, bus.req_we);

    // Transaction FSM; every memory strobe and response output is a register it owns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            size_r       <= 2'b00;
            off_r        <= 2'b00;
            unsigned_r   <= 1'b0;
`ifdef MEM_ACCESS_RMW_EN
            we_r         <= 1'b0;
            wdata_r      <= 16'd0;
`endif
            mem_rd_r     <= 1'b0;
            mem_wr_r     <= 1'b0;
            mem_addr_r   <= '0;
            mem_wdata_r  <= 32'd0;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        size_r     <= bus.req_size;
                        off_r      <= bus.req_addr[1:0];
                        unsigned_r <= bus.req_unsigned;
`ifdef MEM_ACCESS_RMW_EN
                        we_r       <= bus.req_we;
                        wdata_r    <= bus.req_wdata[15:0];
`endif
                        if (accept_err_s) begin
                            state_r      <= ST_RESP;
                            resp_valid_r <= 1'b1;
                            resp_err_r   <= 1'b1;
                            resp_rdata_r <= 32'd0;
                        end else if (!bus.req_we || (bus.req_size != 2'b10)) begin
                            // Loads and sub-word stores both need the current word first.
                            state_r    <= ST_RD;
                            mem_rd_r   <= 1'b1;
                            mem_addr_r <= {bus.req_addr[AW-1:2], 2'b00};
                        end else begin
                            state_r     <= ST_WR;
                            mem_wr_r    <= 1'b1;
                            mem_addr_r  <= {bus.req_addr[AW-1:2], 2'b00};
                            mem_wdata_r <= bus.req_wdata;
                        end
                    end
                end
                ST_RD: begin
                    mem_rd_r <= 1'b0;
`ifdef MEM_ACCESS_RMW_EN
                    if (we_r) begin
                        state_r     <= ST_WR;
                        mem_wr_r    <= 1'b1;
                        mem_wdata_r <= store_merge(bus.mem_rdata, wdata_r, size_r, off_r);
                    end else
`endif
                    begin
                        state_r      <= ST_RESP;
                        mem_addr_r   <= '0;
                        resp_valid_r <= 1'b1;
                        resp_err_r   <= 1'b0;
                        resp_rdata_r <= load_extend(bus.mem_rdata, size_r, off_r, unsigned_r);
                    end
                end
                ST_WR: begin
                    state_r      <= ST_RESP;
                    mem_wr_r     <= 1'b0;
                    mem_addr_r   <= '0;
                    mem_wdata_r  <= 32'd0;
                    resp_valid_r <= 1'b1;
                    resp_err_r   <= 1'b0;
                    resp_rdata_r <= 32'd0;
                end
                ST_RESP: begin
                    if (bus.resp_ready) begin
                        state_r      <= ST_IDLE;
                        resp_valid_r <= 1'b0;
                        resp_err_r   <= 1'b0;
                        resp_rdata_r <= 32'd0;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    mem_rd_r     <= 1'b0;
                    mem_wr_r     <= 1'b0;
                    mem_addr_r   <= '0;
                    mem_wdata_r  <= 32'd0;
                    resp_valid_r <= 1'b0;
                    resp_err_r   <= 1'b0;
                    resp_rdata_r <= 32'd0;
                end
            endcase
        end
    end

    assign bus.req_ready  = (state_r == ST_IDLE) && rst_n;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_rdata = resp_rdata_r;
    assign bus.resp_err   = resp_err_r;
    assign bus.mem_rd     = mem_rd_r;
    assign bus.mem_wr     = mem_wr_r;
    assign bus.mem_addr   = mem_addr_r;
    assign bus.mem_wdata  = mem_wdata_r;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural big-endian word-ported memory.
// Expected values follow MEM_ACCESS_RMW_EN when it is defined for the build.
`timescale 1ns/1ps

module tb_mem_access_unit;
`ifdef MEM_ACCESS_RMW_EN
    localparam bit RMW = 1'b1;
`else
    localparam bit RMW = 1'b0;
`endif

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   wr_count = 0;
    logic [7:0] mem [0:31] = '{default: 8'h00};
    vec_t vecs[$];

    mem_access_unit_if #(.ENTRIES(32)) bus ();

    mem_access_unit #(.ENTRIES(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.mem_rdata = {mem[int'(bus.mem_addr)],     mem[int'(bus.mem_addr) + 1],
                            mem[int'(bus.mem_addr) + 2], mem[int'(bus.mem_addr) + 3]};

    // Memory commits writes on the falling edge inside the WR cycle.
    always @(negedge clk) begin
        if (bus.mem_wr) begin
            mem[int'(bus.mem_addr)]     = bus.mem_wdata[31:24];
            mem[int'(bus.mem_addr) + 1] = bus.mem_wdata[23:16];
            mem[int'(bus.mem_addr) + 2] = bus.mem_wdata[15:8];
            mem[int'(bus.mem_addr) + 3] = bus.mem_wdata[7:0];
            wr_count = wr_count + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic addv(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
        vec_t v;
        v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
        vecs.push_back(v);
    endtask

    task automatic drive_req(input logic we, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = size;
        bus.req_unsigned = uns; bus.req_addr = addr; bus.req_wdata = wdata;
    endtask

    // Called #1 after a posedge with the unit idle; returns response and latency in cycles.
    task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output logic err, output int lat,
                           output logic strobe);
        drive_req(we, size, uns, addr, wdata);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 1;
        strobe = bus.mem_rd | bus.mem_wr;
        while (!bus.resp_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
            strobe = strobe | bus.mem_rd | bus.mem_wr;
        end
        rdata = bus.resp_rdata;
        err = bus.resp_err;
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] rdata;
        logic        err;
        logic        strobe;
        int          lat;
        int          wr0;
        logic [31:0] w8;

        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00; bus.req_unsigned = 1'b0;
        bus.req_addr = 32'd0; bus.req_wdata = 32'd0; bus.resp_ready = 1'b0;

        w8 = RMW ? 32'h1122ABC5 : 32'h11223344;
        //    we    size   uns   addr   wdata          rdata                              err          lat
        addv(1'b1, 2'b10, 1'b0, 32'd8,  32'h11223344, 32'h0,                              1'b0,        2);
        addv(1'b0, 2'b10, 1'b0, 32'd8,  32'h0,        32'h11223344,                       1'b0,        2);
        addv(1'b1, 2'b10, 1'b0, 32'd4,  32'h80FF0000, 32'h0,                              1'b0,        2);
        addv(1'b0, 2'b00, 1'b0, 32'd4,  32'h0,        32'hFFFFFF80,                       1'b0,        2);
        addv(1'b0, 2'b00, 1'b1, 32'd5,  32'h0,        32'h000000FF,                       1'b0,        2);
        addv(1'b0, 2'b01, 1'b0, 32'd4,  32'h0,        32'hFFFF80FF,                       1'b0,        2);
        addv(1'b0, 2'b01, 1'b1, 32'd6,  32'h0,        32'h00000000,                       1'b0,        2);
        addv(1'b1, 2'b00, 1'b0, 32'd10, 32'h000000AB, 32'h0,                              !RMW,        RMW ? 3 : 1);
        addv(1'b0, 2'b10, 1'b0, 32'd8,  32'h0,        RMW ? 32'h1122AB44 : 32'h11223344, 1'b0,        2);
        addv(1'b1, 2'b00, 1'b0, 32'd11, 32'h123456C5, 32'h0,                              !RMW,        RMW ? 3 : 1);
        addv(1'b0, 2'b00, 1'b1, 32'd11, 32'h0,        RMW ? 32'h000000C5 : 32'h00000044, 1'b0,        2);
        addv(1'b0, 2'b00, 1'b0, 32'd11, 32'h0,        RMW ? 32'hFFFFFFC5 : 32'h00000044, 1'b0,        2);
        addv(1'b1, 2'b01, 1'b0, 32'd2,  32'h00001234, 32'h0,                              !RMW,        RMW ? 3 : 1);
        addv(1'b1, 2'b01, 1'b0, 32'd0,  32'hFFFFBEEF, 32'h0,                              !RMW,        RMW ? 3 : 1);
        addv(1'b0, 2'b10, 1'b0, 32'd0,  32'h0,        RMW ? 32'hBEEF1234 : 32'h00000000, 1'b0,        2);
        addv(1'b0, 2'b10, 1'b0, 32'd6,  32'h0,        32'h0,                              1'b1,        1);
        addv(1'b0, 2'b01, 1'b0, 32'd29, 32'h0,        32'h0,                              1'b1,        1);
        addv(1'b0, 2'b10, 1'b0, 32'd28, 32'h0,        32'h0,                              1'b0,        2);
        addv(1'b0, 2'b10, 1'b0, 32'd29, 32'h0,        32'h0,                              1'b1,        1);
        addv(1'b0, 2'b11, 1'b0, 32'd0,  32'h0,        32'h0,                              1'b1,        1);
        addv(1'b1, 2'b11, 1'b0, 32'd4,  32'h5A5A5A5A, 32'h0,                              1'b1,        1);
        addv(1'b1, 2'b10, 1'b0, 32'd2,  32'hDEADBEEF, 32'h0,                              1'b1,        1);
        addv(1'b1, 2'b10, 1'b0, 32'd32, 32'hDEADBEEF, 32'h0,                              1'b1,        1);
        addv(1'b0, 2'b00, 1'b0, 32'd31, 32'h0,        32'h0,                              1'b1,        1);
        addv(1'b0, 2'b00, 1'b0, 32'd28, 32'h0,        32'h0,                              1'b0,        2);
        addv(1'b0, 2'b01, 1'b1, 32'd4,  32'h0,        32'h000080FF,                       1'b0,        2);

        // Reset state
        #1;
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
        chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("rst_mem_strobes", {30'd0, bus.mem_rd, bus.mem_wr}, 32'd0);
        chk("rst_mem_addr", {27'd0, bus.mem_addr}, 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
        #11 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_req_ready", {31'd0, bus.req_ready}, 32'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            run_req(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                    rdata, err, lat, strobe);
            chk($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
            chk($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            if (vecs[i].exp_err) begin
                chk($sformatf("v%0d_no_strobe", i), {31'd0, strobe}, 32'd0);
            end
        end

        // Response back-pressure: outputs hold, a new request is ignored until the handshake.
        wr0 = wr_count;
        drive_req(1'b0, 2'b10, 1'b0, 32'd8, 32'h0);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("stall%0d_resp_valid", c), {31'd0, bus.resp_valid}, 32'd1);
            chk($sformatf("stall%0d_rdata", c), bus.resp_rdata, w8);
            chk($sformatf("stall%0d_req_ready", c), {31'd0, bus.req_ready}, 32'd0);
            if (c == 1) drive_req(1'b1, 2'b10, 1'b0, 32'd0, 32'hDEADBEEF);
            @(posedge clk); #1;
        end
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        bus.req_valid = 1'b0;
        chk("stall_release_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("stall_release_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("stall_no_write", 32'(wr_count), 32'(wr0));
        run_req(1'b0, 2'b10, 1'b0, 32'd0, 32'h0, rdata, err, lat, strobe);
        chk("stall_word0_intact", rdata, RMW ? 32'hBEEF1234 : 32'h00000000);

        // Reset in the middle of a sub-word store aborts it without a write or response.
        run_req(1'b1, 2'b10, 1'b0, 32'd12, 32'hCAFEF00D, rdata, err, lat, strobe);
        wr0 = wr_count;
        drive_req(1'b1, 2'b00, 1'b0, 32'd12, 32'h00000000);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
`ifdef MEM_ACCESS_RMW_EN
        chk("abort_in_rd", {31'd0, bus.mem_rd}, 32'd1);
`endif
        #2 rst_n = 1'b0;
        #1;
        chk("abort_mem_strobes", {30'd0, bus.mem_rd, bus.mem_wr}, 32'd0);
        chk("abort_mem_addr", {27'd0, bus.mem_addr}, 32'd0);
        chk("abort_mem_wdata", bus.mem_wdata, 32'd0);
        chk("abort_resp", {30'd0, bus.resp_valid, bus.resp_err}, 32'd0);
        chk("abort_req_ready", {31'd0, bus.req_ready}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_no_resp", {31'd0, bus.resp_valid}, 32'd0);
        chk("abort_no_write", 32'(wr_count), 32'(wr0));
        run_req(1'b0, 2'b10, 1'b0, 32'd12, 32'h0, rdata, err, lat, strobe);
        chk("abort_lw12", rdata, 32'hCAFEF00D);
        chk("abort_lw12_err", {31'd0, err}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
